// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared types and constants for the switch debounce slice:
//                debounce FSM state encoding, default hold time and a
//                ceiling-log2 helper used to size the hold counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    COUNT_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    COUNT_LOW   = 2'd3
  } deb_state_t;

  // 10 ms hold time at a 25 MHz system clock
  localparam int c_DEBOUNCE_DEFAULT = 250000;

  // Ceiling log2; returns 0 for values of 0 or 1
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One switch channel: two-flop synchronizer, four-state
//                debounce FSM with a hold-time counter, registered level and
//                single-cycle press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release
);

  // Counter must hold DEBOUNCE_CYCLES-1; sized on DEBOUNCE_CYCLES+1 for headroom
  localparam int                 c_CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

  logic               r_sync1;
  logic               r_sync2;
  deb_state_t         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic               r_level;
  logic               r_press;
  logic               r_release;

  deb_state_t         w_state_nx;
  logic [c_CNT_W-1:0] w_count_nx;
  logic               w_level_nx;
  logic               w_press_nx;
  logic               w_release_nx;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, hold counter and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= STABLE_LOW;
      r_count   <= c_CNT_ZERO;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
    end
  end

  // Next-state logic: any disagreement during a count restarts from stable
  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_level_nx   = r_level;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (r_sync2) begin
          w_state_nx = COUNT_HIGH;
          w_count_nx = c_CNT_ONE;
        end
      end
      COUNT_HIGH: begin
        if (!r_sync2) begin
          w_state_nx = STABLE_LOW;
          w_count_nx = c_CNT_ZERO;
        end else if (r_count == c_CNT_LAST) begin
          w_state_nx = STABLE_HIGH;
          w_count_nx = c_CNT_ZERO;
          w_level_nx = 1'b1;
          w_press_nx = 1'b1;
        end else begin
          w_count_nx = r_count + c_CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nx = COUNT_LOW;
          w_count_nx = c_CNT_ONE;
        end
      end
      COUNT_LOW: begin
        if (r_sync2) begin
          w_state_nx = STABLE_HIGH;
          w_count_nx = c_CNT_ZERO;
        end else if (r_count == c_CNT_LAST) begin
          w_state_nx   = STABLE_LOW;
          w_count_nx   = c_CNT_ZERO;
          w_level_nx   = 1'b0;
          w_release_nx = 1'b1;
        end else begin
          w_count_nx = r_count + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nx = STABLE_LOW;
        w_count_nx = c_CNT_ZERO;
        w_level_nx = 1'b0;
      end
    endcase
  end

  assign o_Level   = r_level;
  assign o_Press   = r_press;
  assign o_Release = r_release;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : Debounces NUM_SW raw push-switches into clean levels plus
//                press/release pulses, and flags any press this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
  import switch_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic              o_Any_Press
);

  // One independent debouncer per switch
  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Raw    (i_Switch[gi]),
      .o_Level  (o_Switch[gi]),
      .o_Press  (o_Press[gi]),
      .o_Release(o_Release[gi])
    );
  end

  // Press pulses are already registered, so the OR adds no latency
  assign o_Any_Press = |o_Press;

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=8.
//                Directed scenarios followed by randomized pin activity, all
//                checked against a sliding-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

  localparam int NUM_SW = 4;
  localparam int D      = 8;

  logic              i_Clk = 1'b0;
  logic              i_Rst_L;
  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Switch;
  logic [NUM_SW-1:0] o_Press;
  logic [NUM_SW-1:0] o_Release;
  logic              o_Any_Press;

  always #5 i_Clk = ~i_Clk;

  switch_debounce #(
    .NUM_SW         (NUM_SW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Switch   (i_Switch),
    .o_Switch   (o_Switch),
    .o_Press    (o_Press),
    .o_Release  (o_Release),
    .o_Any_Press(o_Any_Press)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {level, press, release, any_press} per clock edge
  logic [3*NUM_SW:0] exp_q[$];

  // Reference model: pins reach the filter two edges late; a channel flips
  // once the last D filtered samples since its previous flip all disagree
  // with its current level.
  logic [NUM_SW-1:0] m_d1, m_d2, m_level;
  logic [NUM_SW-1:0] m_seen_q[$];
  int                m_since[NUM_SW];
  logic              prev_rst_n = 1'b0;
  logic [NUM_SW-1:0] rnd_pins;

  task automatic check(input string name, input logic [3*NUM_SW:0] act,
                       input logic [3*NUM_SW:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got lvl=%b prs=%b rel=%b any=%b, expected lvl=%b prs=%b rel=%b any=%b",
                  name, $time, act[12:9], act[8:5], act[4:1], act[0],
                  exp[12:9], exp[8:5], exp[4:1], exp[0]);
  endtask

  task automatic model_step(input logic [NUM_SW-1:0] pins, input logic rst_low,
                            output logic [3*NUM_SW:0] exp);
    logic [NUM_SW-1:0] seen, press, rel;
    bit all_diff;
    press = '0;
    rel   = '0;
    if (rst_low) begin
      m_d1 = '0; m_d2 = '0; m_level = '0;
      m_seen_q.delete();
      for (int ch = 0; ch < NUM_SW; ch++) m_since[ch] = 0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = pins;
      m_seen_q.push_back(seen);
      if (m_seen_q.size() > D) void'(m_seen_q.pop_front());
      for (int ch = 0; ch < NUM_SW; ch++) begin
        m_since[ch]++;
        if (m_since[ch] >= D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (m_seen_q[m_seen_q.size()-1-j][ch] == m_level[ch]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) press[ch] = 1'b1;
            else             rel[ch]   = 1'b1;
            m_since[ch] = 0;
          end
        end
      end
    end
    exp = {m_level, press, rel, |press};
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rise
  task automatic drive(input logic [NUM_SW-1:0] pins, input logic rst_n_v);
    logic [3*NUM_SW:0] exp;
    @(negedge i_Clk);
    i_Switch = pins;
    i_Rst_L  = rst_n_v;
    if (prev_rst_n && !rst_n_v) begin
      #1;
      check("async_reset", {o_Switch, o_Press, o_Release, o_Any_Press}, '0);
    end
    prev_rst_n = rst_n_v;
    model_step(pins, !rst_n_v, exp);
    exp_q.push_back(exp);
  endtask

  task automatic hold(input logic [NUM_SW-1:0] pins, input int n);
    for (int k = 0; k < n; k++) drive(pins, 1'b1);
  endtask

  // Monitor: compare every post-edge output against the predicted response
  initial begin
    logic [3*NUM_SW:0] e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {o_Switch, o_Press, o_Release, o_Any_Press}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_Rst_L  = 1'b0;
    i_Switch = '1;
    // Switches held pressed through reset
    for (int k = 0; k < 3; k++) drive(4'b1111, 1'b0);
    hold(4'b1111, 20);
    hold(4'b0000, 12);
    // Clean press and release on bit 0
    hold(4'b0001, 20);
    hold(4'b0000, 12);
    // Bouncing press on bit 1
    hold(4'b0010, 3); hold(4'b0000, 3); hold(4'b0010, 3); hold(4'b0000, 3);
    hold(4'b0010, 14);
    hold(4'b0000, 12);
    // Glitch one short of the hold time, then exactly the hold time
    hold(4'b0100, 7);
    hold(4'b0000, 12);
    hold(4'b0100, 8);
    hold(4'b0000, 12);
    // Simultaneous presses on 0/3 while 2 releases
    hold(4'b0100, 12);
    hold(4'b1001, 12);
    hold(4'b0000, 12);
    // Reset in the middle of a press count, then with the level high
    hold(4'b0001, 7);
    drive(4'b0001, 1'b0);
    hold(4'b0001, 15);
    drive(4'b0001, 1'b0);
    hold(4'b0001, 12);
    hold(4'b0000, 12);
    // Randomized pin activity with occasional resets
    rnd_pins = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < NUM_SW; ch++)
        if ($urandom_range(0, 9) == 0) rnd_pins[ch] = ~rnd_pins[ch];
      if ($urandom_range(0, 299) == 0) drive(rnd_pins, 1'b0);
      else                             drive(rnd_pins, 1'b1);
    end
    @(posedge i_Clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_switch_debounce
`default_nettype wire
